// File: rtl/iq_fir_filter.sv
// iq_fir_filter
// Dual-channel (I/Q) time-multiplexed FIR filter. Both channels share one set
// of coefficients and one handshake. After a sample pair is accepted, one tap
// per channel is processed each clock. The result is then rounded (half toward
// +inf), arithmetically shifted right by SHIFT and saturated to OUT_W bits.
//
// Optional build macro: IQ_FIR_OVF_EN adds a sticky saturation flag on port
// ovf. The flag is cleared only by resetn.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   data_in_I   I input sample, signed DATA_W
//   data_in_Q   Q input sample, signed DATA_W
//   in_valid    input sample pair valid
//   pret        ready to accept a sample pair (high in IDLE)
//   out_valid   one-cycle strobe, data_out_I/Q valid
//   data_out_I  filtered I, signed OUT_W, held between strobes
//   data_out_Q  filtered Q, signed OUT_W, held between strobes
//   ovf         (IQ_FIR_OVF_EN only) sticky saturation flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; pret=1
// MAC   | one multiply-accumulate per channel per cycle, tap k
// OUT   | results registered; out_valid=1 for this single cycle
module iq_fir_filter #(
    parameter int DATA_W = 5,
    parameter int OUT_W  = 5,
    parameter int COEF_W = 6,
    parameter int NTAPS  = 8,
    parameter int SHIFT  = 3,
    parameter logic [NTAPS*COEF_W-1:0] COEFS = {8{6'sd1}}
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] data_in_I,
    input  logic [DATA_W-1:0] data_in_Q,
    input  logic              in_valid,
`ifdef IQ_FIR_OVF_EN
    output logic              ovf,
`endif
    output logic              pret,
    output logic              out_valid,
    output logic [OUT_W-1:0]  data_out_I,
    output logic [OUT_W-1:0]  data_out_Q
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int KW     = $clog2(NTAPS);
    localparam int RW     = ACC_W + 1;

    localparam logic signed [RW-1:0] RND  = RW'((1 << SHIFT) >> 1);
    localparam logic signed [RW-1:0] OMAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN = RW'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]             k;
    logic signed [DATA_W-1:0]  x_i [NTAPS];
    logic signed [DATA_W-1:0]  x_q [NTAPS];
    logic signed [COEF_W-1:0]  coef [NTAPS];
    logic signed [ACC_W-1:0]   acc_i;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [PROD_W-1:0]  prod_i;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   sum_i;
    logic signed [ACC_W-1:0]   sum_q;
    logic signed [RW-1:0]      r_i;
    logic signed [RW-1:0]      r_q;
    logic                      last_tap;

    genvar g;
    for (g = 0; g < NTAPS; g++) begin : g_coef
        assign coef[g] = COEFS[g*COEF_W +: COEF_W];
    end

    // Round half toward +inf, then arithmetic shift. One guard bit keeps the
    // rounding constant from wrapping a full-scale accumulator.
    function automatic logic signed [RW-1:0] rnd_shift(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] ext;
        ext = $signed({a[ACC_W-1], a});
        return (ext + RND) >>> SHIFT;
    endfunction

    function automatic logic [OUT_W-1:0] clamp(input logic signed [RW-1:0] r);
        logic [OUT_W-1:0] v;
        v = r[OUT_W-1:0];
        if (r > OMAX) begin
            v = OMAX[OUT_W-1:0];
        end else if (r < OMIN) begin
            v = OMIN[OUT_W-1:0];
        end
        return v;
    endfunction

    assign prod_i   = x_i[k] * coef[k];
    assign prod_q   = x_q[k] * coef[k];
    assign sum_i    = acc_i + $signed({{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i});
    assign sum_q    = acc_q + $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
    assign last_tap = (k == KW'(NTAPS - 1));

    // The final sum is rounded and registered on the same edge that retires the
    // last tap, so the strobe lands in the OUT cycle with data already valid.
    assign r_i = rnd_shift(sum_i);
    assign r_q = rnd_shift(sum_q);

    always_comb begin
        state_nxt = state;
        pret      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                pret = 1'b1;
                if (in_valid) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            k          <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            data_out_I <= '0;
            data_out_Q <= '0;
            for (int t = 0; t < NTAPS; t++) begin
                x_i[t] <= '0;
                x_q[t] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int t = NTAPS - 1; t > 0; t--) begin
                            x_i[t] <= x_i[t-1];
                            x_q[t] <= x_q[t-1];
                        end
                        x_i[0] <= $signed(data_in_I);
                        x_q[0] <= $signed(data_in_Q);
                        acc_i  <= '0;
                        acc_q  <= '0;
                        k      <= '0;
                    end
                end
                MAC: begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    if (last_tap) begin
                        k          <= '0;
                        data_out_I <= clamp(r_i);
                        data_out_Q <= clamp(r_q);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IQ_FIR_OVF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (state == MAC && last_tap) begin
            if (r_i > OMAX || r_i < OMIN || r_q > OMAX || r_q < OMIN) begin
                ovf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iq_fir_filter.sv
module tb_iq_fir_filter;

    localparam int NT = 8;
    localparam logic [47:0] C2 = {6'sd4, -6'sd2, 6'sd0, 6'sd7, -6'sd5, 6'sd2, -6'sd1, 6'sd3};

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       resetn;
    logic [4:0] di [3];
    logic [4:0] dq [3];
    logic       iv [3];
    logic       pr [3];
    logic       ov [3];
    logic [4:0] oi [3];
    logic [4:0] oq [3];
`ifdef IQ_FIR_OVF_EN
    logic       ovfs [3];
`endif

    int total = 0;
    int bad   = 0;

    int cf [3][NT];
    int sh [3];
    int hi [3][NT];
    int hq [3][NT];
    bit msat [3];

    iq_fir_filter #(.SHIFT(3)) u0 (
        .clk(clk), .resetn(resetn), .data_in_I(di[0]), .data_in_Q(dq[0]), .in_valid(iv[0]),
`ifdef IQ_FIR_OVF_EN
        .ovf(ovfs[0]),
`endif
        .pret(pr[0]), .out_valid(ov[0]), .data_out_I(oi[0]), .data_out_Q(oq[0]));

    iq_fir_filter #(.SHIFT(0)) u1 (
        .clk(clk), .resetn(resetn), .data_in_I(di[1]), .data_in_Q(dq[1]), .in_valid(iv[1]),
`ifdef IQ_FIR_OVF_EN
        .ovf(ovfs[1]),
`endif
        .pret(pr[1]), .out_valid(ov[1]), .data_out_I(oi[1]), .data_out_Q(oq[1]));

    iq_fir_filter #(.SHIFT(2), .COEFS(C2)) u2 (
        .clk(clk), .resetn(resetn), .data_in_I(di[2]), .data_in_Q(dq[2]), .in_valid(iv[2]),
`ifdef IQ_FIR_OVF_EN
        .ovf(ovfs[2]),
`endif
        .pret(pr[2]), .out_valid(ov[2]), .data_out_I(oi[2]), .data_out_Q(oq[2]));

    // Reference: dot product of the last NT accepted samples with the taps,
    // then floor((acc + half) / 2^shift) clamped to the 5-bit signed range.
    function automatic int ref_out(input int s, input int ch, output bit sat);
        int acc;
        acc = 0;
        for (int t = 0; t < NT; t++) begin
            acc += ((ch == 0) ? hi[s][t] : hq[s][t]) * cf[s][t];
        end
        acc = (acc + ((1 << sh[s]) >> 1)) >>> sh[s];
        sat = 1'b0;
        if (acc > 15) begin
            acc = 15;
            sat = 1'b1;
        end else if (acc < -16) begin
            acc = -16;
            sat = 1'b1;
        end
        return acc;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            msat[s] = 1'b0;
            for (int t = 0; t < NT; t++) begin
                hi[s][t] = 0;
                hq[s][t] = 0;
            end
        end
    endtask

    task automatic model_push(input int s, input int vi, input int vq);
        for (int t = NT - 1; t > 0; t--) begin
            hi[s][t] = hi[s][t-1];
            hq[s][t] = hq[s][t-1];
        end
        hi[s][0] = vi;
        hq[s][0] = vq;
    endtask

    // Compares the strobe data (and ovf) of dut s against the model.
    task automatic check_data(input int s, input string tag);
        int ei, eq;
        bit si, sq;
        ei = ref_out(s, 0, si);
        eq = ref_out(s, 1, sq);
        msat[s] = msat[s] | si | sq;
        total++;
        if ($signed(oi[s]) !== ei) begin
            bad++;
            $display("FAIL %s dut%0d data_out_I got %0d want %0d", tag, s, $signed(oi[s]), ei);
        end
        total++;
        if ($signed(oq[s]) !== eq) begin
            bad++;
            $display("FAIL %s dut%0d data_out_Q got %0d want %0d", tag, s, $signed(oq[s]), eq);
        end
`ifdef IQ_FIR_OVF_EN
        total++;
        if (ovfs[s] !== msat[s]) begin
            bad++;
            $display("FAIL %s dut%0d ovf got %b want %b", tag, s, ovfs[s], msat[s]);
        end
`endif
    endtask

    task automatic do_accept(input int s, input int vi, input int vq);
        int n;
        n = 0;
        @(negedge clk);
        while (pr[s] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pr[s] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_wait dut%0d pret got %b want 1", s, pr[s]);
        end
        di[s] = 5'(vi);
        dq[s] = 5'(vq);
        iv[s] = 1'b1;
        @(posedge clk);
        model_push(s, vi, vq);
        #1;
        iv[s] = 1'b0;
        di[s] = '0;
        dq[s] = '0;
    endtask

    task automatic wait_strobe(input int s, input string tag);
        int lat, plow;
        lat  = 0;
        plow = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (pr[s] === 1'b0) plow++;
            if (ov[s] === 1'b1 || lat >= 40) break;
        end
        total++;
        if (ov[s] !== 1'b1) begin
            bad++;
            $display("FAIL %s dut%0d out_valid timeout after %0d cycles", tag, s, lat);
            return;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL %s dut%0d latency got %0d want 9", tag, s, lat);
        end
        total++;
        if (plow !== 9) begin
            bad++;
            $display("FAIL %s dut%0d pret_low cycles got %0d want 9", tag, s, plow);
        end
        check_data(s, tag);
        @(negedge clk);
        total++;
        if (ov[s] !== 1'b0 || pr[s] !== 1'b1 || $signed(oi[s]) !== ref_out(s, 0, plow[0])) begin
            bad++;
            $display("FAIL %s dut%0d after_strobe ov=%b pret=%b I=%0d want ov=0 pret=1 held", tag, s, ov[s], pr[s], $signed(oi[s]));
        end
    endtask

    task automatic xfer(input int s, input int vi, input int vq, input string tag);
        do_accept(s, vi, vq);
        wait_strobe(s, tag);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if (pr[s] !== 1'b1 || ov[s] !== 1'b0 || oi[s] !== 5'd0 || oq[s] !== 5'd0) begin
                bad++;
                $display("FAIL reset dut%0d pret=%b ov=%b I=%0d Q=%0d want 1 0 0 0", s, pr[s], ov[s], oi[s], oq[s]);
            end
`ifdef IQ_FIR_OVF_EN
            total++;
            if (ovfs[s] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ovf dut%0d got %b want 0", s, ovfs[s]);
            end
`endif
        end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_impulse();
        xfer(0, 12, 0, "impulse_I");
        for (int n = 0; n < 9; n++) xfer(0, 0, 0, "impulse_I");
        xfer(0, 0, -12, "impulse_Q");
        for (int n = 0; n < 9; n++) xfer(0, 0, 0, "impulse_Q");
    endtask

    task automatic test_step();
        for (int n = 0; n < 10; n++) xfer(0, 15, 0, "step");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 10; n++) xfer(1, 15, -16, "sat_shift0");
    endtask

    task automatic test_random();
        int a, b;
        for (int n = 0; n < 30; n++) begin
            a = int'($urandom_range(31, 0)) - 16;
            b = int'($urandom_range(31, 0)) - 16;
            xfer(2, a, b, "rand_coefs");
        end
        for (int n = 0; n < 20; n++) begin
            a = int'($urandom_range(31, 0)) - 16;
            b = int'($urandom_range(31, 0)) - 16;
            xfer(0, a, b, "rand_default");
        end
    endtask

    task automatic test_back_to_back();
        int v, nstrobe, last;
        v = int'($urandom_range(31, 0)) - 16;
        nstrobe = 0;
        last = 0;
        @(negedge clk);
        di[0] = 5'(v);
        dq[0] = 5'(-v - 1);
        iv[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ov[0] === 1'b1) begin
                nstrobe++;
                model_push(0, v, -v - 1);
                total++;
                if (n - last !== ((last == 0) ? 9 : 10)) begin
                    bad++;
                    $display("FAIL b2b_spacing strobe at %0d prev %0d", n, last);
                end
                last = n;
                check_data(0, "b2b");
            end
        end
        iv[0] = 1'b0;
        di[0] = '0;
        dq[0] = '0;
        total++;
        if (nstrobe !== 4) begin
            bad++;
            $display("FAIL b2b_count got %0d want 4", nstrobe);
        end
        repeat (12) @(negedge clk);
        total++;
        if (pr[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle pret got %b want 1", pr[0]);
        end
    endtask

    task automatic test_mac_pulses();
        int nstrobe, at;
        nstrobe = 0;
        at = 0;
        do_accept(0, 9, -7);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ov[0] === 1'b1) begin
                nstrobe++;
                at = n;
                check_data(0, "mac_pulse");
            end
            if (n == 3 || n == 6 || n == 9) begin
                iv[0] = 1'b1;
                di[0] = 5'd13;
                dq[0] = 5'd21;
            end else begin
                iv[0] = 1'b0;
                di[0] = '0;
                dq[0] = '0;
            end
        end
        iv[0] = 1'b0;
        total++;
        if (nstrobe !== 1 || at !== 9) begin
            bad++;
            $display("FAIL mac_pulse strobes got %0d at %0d want 1 at 9", nstrobe, at);
        end
        xfer(0, 1, 1, "after_pulse");
    endtask

    task automatic test_reset_mid();
        int nstrobe;
        nstrobe = 0;
        xfer(0, 7, 5, "pre_reset");
        xfer(0, -3, 11, "pre_reset");
        do_accept(0, 9, 9);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (ov[0] !== 1'b0 || pr[0] !== 1'b1 || oi[0] !== 5'd0 || oq[0] !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid pret=%b ov=%b I=%0d Q=%0d want 1 0 0 0", pr[0], ov[0], oi[0], oq[0]);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (ov[0] === 1'b1) nstrobe++;
        end
        total++;
        if (nstrobe !== 0) begin
            bad++;
            $display("FAIL reset_mid_strobe got %0d strobes want 0", nstrobe);
        end
        xfer(0, 12, 0, "post_reset_impulse");
        for (int n = 0; n < 9; n++) xfer(0, 0, 0, "post_reset_impulse");
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0;
            di[s] = '0;
            dq[s] = '0;
            for (int t = 0; t < NT; t++) cf[s][t] = 1;
        end
        sh[0] = 3;
        sh[1] = 0;
        sh[2] = 2;
        cf[2][0] = 3;
        cf[2][1] = -1;
        cf[2][2] = 2;
        cf[2][3] = -5;
        cf[2][4] = 7;
        cf[2][5] = 0;
        cf[2][6] = -2;
        cf[2][7] = 4;
        model_reset();
        test_reset();
        test_impulse();
        test_step();
        test_saturation();
        test_random();
        test_back_to_back();
        test_mac_pulses();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_fir_filter.md
Name: iq_fir_filter

Overview:
- Parametrised dual-channel (I/Q) FIR filter for the iq_demod path; successor to the single-channel 5-bit `filter`.
- One instance filters both I and Q with shared coefficients and a shared handshake.
- Time-multiplexed: one tap per clock per channel, two multipliers total.
- Output is rounded, scaled by a right shift and saturated back to sample width.

Parameters:
- DATA_W, 5: input sample width, signed two's complement.
- OUT_W, 5: output sample width, signed.
- COEF_W, 6: coefficient width, signed.
- NTAPS, 8: number of taps, >=2.
- SHIFT, 3: arithmetic right shift applied to the accumulator before saturation, >=0.
- COEFS, {8{6'sd1}}: packed NTAPS*COEF_W vector; tap k occupies bits [k*COEF_W +: COEF_W]; tap 0 multiplies the newest sample.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- data_in_I  in  DATA_W  I sample, signed.
- data_in_Q  in  DATA_W  Q sample, signed.
- in_valid  in  1  input sample pair valid.
- pret  out  1  ready to accept a sample pair.
- out_valid  out  1  one-cycle strobe; data_out_I and data_out_Q are valid.
- data_out_I  out  OUT_W  filtered I, signed.
- data_out_Q  out  OUT_W  filtered Q, signed.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE; both delay lines, both accumulators and the tap counter clear to 0.
  - Outputs: pret=1, out_valid=0, data_out_I=0, data_out_Q=0.
  - Reset asserted mid-MAC aborts the computation; no out_valid for that sample.
- Accumulator width: ACC_W = DATA_W + COEF_W + $clog2(NTAPS). Products and sums are signed and sign-extended to ACC_W, so the accumulator never wraps.
- FSM has three states:
  - IDLE:
    - pret=1.
    - Accept occurs on a cycle with in_valid=1.
    - On accept, shift data_in_I/Q into position 0 of their NTAPS-deep delay lines; the oldest sample drops out.
    - Clear both accumulators and the tap counter k, then go to MAC.
  - MAC:
    - pret=0.
    - Each cycle: acc_I += x_I[k]*COEFS[k] and acc_Q += x_Q[k]*COEFS[k], then k++.
    - After the k=NTAPS-1 cycle, go to OUT.
    - in_valid in this state is ignored; the sample is not queued.
  - OUT:
    - Compute r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half toward +inf.
    - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Register the results to data_out_I/Q and pulse out_valid=1 for one cycle, then return to IDLE.
    - pret=1 again on the cycle after out_valid.
- Timing:
  - Accept at edge 0 gives out_valid high during cycle NTAPS+1 (9 for defaults).
  - Throughput is one pair per NTAPS+2 cycles.
- data_out_I/Q hold their value between strobes.
- I and Q always complete on the same cycle.

Optional Feature:
- Macro: IQ_FIR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is a sticky flag: it sets in the cycle out_valid pulses if either channel saturated.
  - It clears only on resetn.
- Undefined:
  - Port ovf is absent and the saturation logic is unchanged.

Test Plan:
- Impulse, defaults: I=+12 once, then zeros; Q=0 -> data_out_I = 2 (12/8=1.5 rounded up) for exactly 8 consecutive strobes, then 0; data_out_Q = 0 throughout.
- Negative rounding: Q=-12 once, then zeros -> data_out_Q = -1 for 8 strobes, then 0.
- Step, defaults: I=+15 constant -> outputs 2,4,6,8,9,11,13,15,15,...; out_valid exactly 9 cycles after each accept; pret low for 9 cycles after each accept.
- Saturation, SHIFT=0:
  - I=+15 constant -> 15,15,... (raw 30,45 clamp).
  - Q=-16 constant -> -16,...
  - With IQ_FIR_OVF_EN, ovf rises at the 2nd strobe and stays high.
- Handshake: hold in_valid=1 continuously -> exactly one accept per 10 cycles; in_valid pulses during MAC produce no accept and no extra strobe.
- Reset mid-operation: resetn low at cycle 4 of MAC -> no out_valid; all outputs 0, pret=1; the next impulse response matches the impulse test exactly, showing the delay lines were cleared.
